// File: rtl/alu_pkg.sv
// Shared types for the RISC16 execute stage: alu function codes,
// the multiply opcode that lives outside the alu encoding, and the
// controller state encoding.
package alu_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [3:0] {
        NAND = 4'd0,
        AND  = 4'd1,
        NOR  = 4'd2,
        OR   = 4'd3,
        ADD  = 4'd4,
        SUB  = 4'd5,
        XOR  = 4'd6,
        SL   = 4'd7,
        SR   = 4'd8
    } alu_func_e;

    localparam logic [3:0] OP_MUL = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        MUL_ADD = 3'd2,
        MUL_SH  = 3'd3,
        DONE    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit alu. Shift amounts use only b[4:0], so shifting
// by 16..31 pushes every bit out and yields zero.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] out_o
);

    // Select the result of the requested function; unknown codes give zero.
    always_comb begin
        out_o = '0;
        case (func_i)
            NAND:    out_o = ~(a_i & b_i);
            AND:     out_o = a_i & b_i;
            NOR:     out_o = ~(a_i | b_i);
            OR:      out_o = a_i | b_i;
            ADD:     out_o = a_i + b_i;
            SUB:     out_o = a_i - b_i;
            XOR:     out_o = a_i ^ b_i;
            SL:      out_o = a_i << b_i[4:0];
            SR:      out_o = a_i >> b_i[4:0];
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_regfile.sv
// 8x16 register file: two operand read ports, one debug read port and a
// single synchronous write port. r0 always reads zero and ignores writes.
module alu_ctrl_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [2:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [2:0]       raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [2:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [2:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] regs_q [NREGS];

    // Clear every register on reset; afterwards commit writes, dropping any aimed at r0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 3'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports are purely combinational, with r0 forced to zero.
    always_comb begin
        rdata_a_o  = (raddr_a_i  == 3'd0) ? '0 : regs_q[raddr_a_i];
        rdata_b_o  = (raddr_b_i  == 3'd0) ? '0 : regs_q[raddr_b_i];
        dbg_data_o = (dbg_addr_i == 3'd0) ? '0 : regs_q[dbg_addr_i];
    end

endmodule

// File: rtl/alu_ctrl.sv
// Execute-stage controller. Takes one decoded op per handshake, reads its
// operands, drives the external alu for one cycle (or a shift-and-add
// sequence for MUL), writes the result back and holds it on the done port
// until the consumer takes it.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic [2:0]       in_rd_i,
    input  logic [2:0]       in_rs_i,
    input  logic [2:0]       in_rt_i,
    input  logic             in_use_imm_i,
    input  logic [WIDTH-1:0] in_imm_i,
    output logic [3:0]       alu_func_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_out_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic [2:0]       done_rd_o,
    output logic [WIDTH-1:0] done_data_o,
    output logic             done_err_o,
    input  logic [2:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, acc_q, done_data_q;
    logic [3:0]       op_q;
    logic [2:0]       rd_q;
    logic             err_q;

    logic [WIDTH-1:0] rdata_a, rdata_b, b_sel, q_shift;
    logic             accept, illegal, q_last;
    logic             rf_we;
    logic [WIDTH-1:0] rf_wdata;

    assign accept  = in_valid_i && (state_q == IDLE);
    assign b_sel   = in_use_imm_i ? in_imm_i : rdata_b;
    assign illegal = !((in_op_i <= 4'd8) || (MUL_EN && (in_op_i == OP_MUL)));
    // b_q doubles as the multiplier; its shifted value decides when MUL ends.
    assign q_shift = {1'b0, b_q[WIDTH-1:1]};
    assign q_last  = (q_shift == '0);

    assign done_rd_o   = rd_q;
    assign done_data_o = done_data_q;
    assign done_err_o  = err_q;

    alu_ctrl_regfile #(
        .NREGS(NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (in_rs_i),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (in_rt_i),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o)
    );

    // State register; reset aborts whatever op is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: ALU and illegal ops take one EXEC cycle, MUL walks the multiplier bits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    if (!illegal && (in_op_i == OP_MUL)) begin
                        state_d = b_sel[0] ? MUL_ADD : MUL_SH;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC:    state_d = DONE;
            MUL_ADD: state_d = MUL_SH;
            MUL_SH: begin
                if (q_last) begin
                    state_d = DONE;
                end else begin
                    state_d = q_shift[0] ? MUL_ADD : MUL_SH;
                end
            end
            DONE: begin
                if (done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drive the alu, handshake flags and regfile write strobe from the current state.
    always_comb begin
        alu_func_o   = ADD;
        alu_a_o      = '0;
        alu_b_o      = '0;
        rf_we        = 1'b0;
        rf_wdata     = alu_out_i;
        in_ready_o   = (state_q == IDLE);
        done_valid_o = (state_q == DONE);
        case (state_q)
            EXEC: begin
                if (!err_q) begin
                    alu_func_o = op_q;
                    alu_a_o    = a_q;
                    alu_b_o    = b_q;
                    rf_we      = 1'b1;
                end
            end
            MUL_ADD: begin
                alu_func_o = ADD;
                alu_a_o    = acc_q;
                alu_b_o    = a_q;
            end
            MUL_SH: begin
                alu_func_o = SL;
                alu_a_o    = a_q;
                alu_b_o    = 16'd1;
                rf_we      = q_last;
                rf_wdata   = acc_q;
            end
            default: ;
        endcase
    end

    // Operand latching at accept, then accumulator/multiplicand updates and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            done_data_q <= '0;
            op_q        <= ADD;
            rd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= rdata_a;
                        b_q   <= b_sel;
                        acc_q <= '0;
                        op_q  <= in_op_i;
                        rd_q  <= in_rd_i;
                        err_q <= illegal;
                    end
                end
                EXEC: begin
                    done_data_q <= err_q ? '0 : alu_out_i;
                end
                MUL_ADD: begin
                    acc_q <= alu_out_i;
                end
                MUL_SH: begin
                    a_q <= alu_out_i;
                    b_q <= q_shift;
                    if (q_last) begin
                        done_data_q <= acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
